// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the AXI-Lite asynchronous SRAM controller.
package sram_ctrl_pkg;

    // Controller states: one outstanding transaction, fixed two-cycle access windows.
    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_HOLD,
        WR_RESP,
        RD,
        RD_SAMPLE,
        RD_RESP
    } sram_ctrl_state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Next-cycle pin state handed to the pad stage; drive enables the data bus.
    typedef struct packed {
        logic ce_n;
        logic we_n;
        logic oe_n;
        logic drive;
    } sram_pins_t;

    // Chip deselected, strobes inactive, bus released.
    localparam sram_pins_t PINS_IDLE     = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, drive: 1'b0};
    // Write strobe active with address and data driven.
    localparam sram_pins_t PINS_WRITE    = '{ce_n: 1'b0, we_n: 1'b0, oe_n: 1'b1, drive: 1'b1};
    // Write strobe released while address and data are held for hold time.
    localparam sram_pins_t PINS_WR_HOLD  = '{ce_n: 1'b0, we_n: 1'b1, oe_n: 1'b1, drive: 1'b1};
    // Output enable active, bus left to the SRAM.
    localparam sram_pins_t PINS_READ     = '{ce_n: 1'b0, we_n: 1'b1, oe_n: 1'b0, drive: 1'b0};

endpackage

// File: rtl/sram_io_pad.sv
// SRAM pin stage: registers the address and active-low strobes and owns the
// single tristate driver of the bidirectional data bus, so the inout lives in
// one place and can be replaced by a vendor I/O primitive later.
module sram_io_pad
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  sram_pins_t           i_pins,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_BITS-1:0] i_wdata,
    output logic [DATA_BITS-1:0] o_rdata,
    output logic [ADDR_BITS-1:0] o_sram_addr,
    output logic                 o_sram_ce_n,
    output logic                 o_sram_we_n,
    output logic                 o_sram_oe_n,
    inout  wire  [DATA_BITS-1:0] io_sram_data
);

    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;
    logic                 r_ce_n;
    logic                 r_we_n;
    logic                 r_oe_n;
    logic                 r_drive;

    // Register every pin so the SRAM sees clean strobes aligned to clk.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_drive <= 1'b0;
        end else begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_ce_n  <= i_pins.ce_n;
            r_we_n  <= i_pins.we_n;
            r_oe_n  <= i_pins.oe_n;
            r_drive <= i_pins.drive;
        end
    end

    assign o_sram_addr = r_addr;
    assign o_sram_ce_n = r_ce_n;
    assign o_sram_we_n = r_we_n;
    assign o_sram_oe_n = r_oe_n;

    // The pad only drives while output enable is inactive, so it cannot fight the SRAM.
    assign io_sram_data = (r_drive && r_oe_n) ? r_wdata : {DATA_BITS{1'bz}};
    assign o_rdata      = io_sram_data;

    // Write and read strobes must never be active together.
    a_no_we_oe_overlap: assert property (@(posedge clk) disable iff (reset) !(!r_we_n && !r_oe_n));

endmodule

// File: rtl/sram_ctrl_axil.sv
// AXI-Lite slave that turns single reads and writes into fixed two-cycle
// accesses on an asynchronous SRAM. One transaction is outstanding at a time;
// simultaneous read and write requests are arbitrated round-robin.
module sram_ctrl_axil
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [DATA_BITS-1:0] s_axi_wdata,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ADDR_BITS-1:0] s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [DATA_BITS-1:0] s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic [ADDR_BITS-1:0] sram_io_addr,
    inout  wire  [DATA_BITS-1:0] sram_io_data,
    output logic                 sram_io_we_n,
    output logic                 sram_io_oe_n,
    output logic                 sram_io_ce_n
);

    sram_ctrl_state_t     r_state;
    logic                 r_last_grant_wr;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_bvalid;
    logic                 r_rvalid;

    logic                 w_idle;
    logic                 w_wr_elig;
    logic                 w_rd_elig;
    logic                 w_wr_grant;
    logic                 w_rd_grant;
    sram_pins_t           w_pins;
    logic [ADDR_BITS-1:0] w_pin_addr;
    logic [DATA_BITS-1:0] w_pin_wdata;
    logic [DATA_BITS-1:0] w_pad_rdata;

    // A write needs both address and data; a read needs only its address.
    assign w_idle    = (r_state == IDLE) && !reset;
    assign w_wr_elig = s_axi_awvalid && s_axi_wvalid;
    assign w_rd_elig = s_axi_arvalid;

    // When both kinds contend, the one not served last time wins.
    assign w_wr_grant = w_idle && w_wr_elig && (!w_rd_elig || !r_last_grant_wr);
    assign w_rd_grant = w_idle && w_rd_elig && (!w_wr_elig ||  r_last_grant_wr);

    // Address and data channels of a write are always accepted in the same cycle.
    assign s_axi_awready = w_wr_grant;
    assign s_axi_wready  = w_wr_grant;
    assign s_axi_arready = w_rd_grant;

    assign s_axi_bresp  = AXI_RESP_OKAY;
    assign s_axi_rresp  = AXI_RESP_OKAY;
    assign s_axi_bvalid = r_bvalid;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;

    // Transaction sequencer: latches the request, walks the access window, holds the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_last_grant_wr <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_rdata         <= '0;
            r_bvalid        <= 1'b0;
            r_rvalid        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_grant) begin
                        r_state         <= WR;
                        r_addr          <= s_axi_awaddr;
                        r_wdata         <= s_axi_wdata;
                        r_last_grant_wr <= 1'b1;
                    end else if (w_rd_grant) begin
                        r_state         <= RD;
                        r_addr          <= s_axi_araddr;
                        r_last_grant_wr <= 1'b0;
                    end
                end
                WR: begin
                    r_state <= WR_HOLD;
                end
                WR_HOLD: begin
                    r_state  <= WR_RESP;
                    r_bvalid <= 1'b1;
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        r_state  <= IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                RD: begin
                    r_state <= RD_SAMPLE;
                end
                RD_SAMPLE: begin
                    // The bus has been stable for a full cycle; capture it as the edge closes the window.
                    r_state  <= RD_RESP;
                    r_rdata  <= w_pad_rdata;
                    r_rvalid <= 1'b1;
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        r_state  <= IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Decode the pin state for the next cycle so the pad registers it in step with the FSM.
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_pins      = PINS_IDLE;
        w_pin_addr  = r_addr;
        w_pin_wdata = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_wr_grant) begin
                    w_pins      = PINS_WRITE;
                    w_pin_addr  = s_axi_awaddr;
                    w_pin_wdata = s_axi_wdata;
                end else if (w_rd_grant) begin
                    w_pins     = PINS_READ;
                    w_pin_addr = s_axi_araddr;
                end
            end
            WR:      w_pins = PINS_WR_HOLD;
            RD:      w_pins = PINS_READ;
            default: w_pins = PINS_IDLE;
        endcase
    end

    sram_io_pad #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_pad (
        .clk          (clk),
        .reset        (reset),
        .i_pins       (w_pins),
        .i_addr       (w_pin_addr),
        .i_wdata      (w_pin_wdata),
        .o_rdata      (w_pad_rdata),
        .o_sram_addr  (sram_io_addr),
        .o_sram_ce_n  (sram_io_ce_n),
        .o_sram_we_n  (sram_io_we_n),
        .o_sram_oe_n  (sram_io_oe_n),
        .io_sram_data (sram_io_data)
    );

    // Response channels are mutually exclusive with a single outstanding transaction.
    a_one_response: assert property (@(posedge clk) disable iff (reset) !(r_bvalid && r_rvalid));

endmodule

// File: tb/tb_sram_ctrl_axil.sv
// Bench for sram_ctrl_axil at ADDR_BITS=4, DATA_BITS=2 with a behavioural
// asynchronous SRAM. Stimulus pushes expected responses into a scoreboard;
// a monitor pops and compares on every B/R handshake.
module tb_sram_ctrl_axil;
    import sram_ctrl_pkg::*;

    localparam int AB = 4;
    localparam int DB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AB-1:0] s_axi_awaddr;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [DB-1:0] s_axi_wdata;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [AB-1:0] s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [DB-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [AB-1:0] sram_io_addr;
    wire  [DB-1:0] sram_io_data;
    logic          sram_io_we_n;
    logic          sram_io_oe_n;
    logic          sram_io_ce_n;

    logic [DB-1:0] mem [16];

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int overlap_cnt = 0;
    int split_cnt   = 0;

    typedef struct packed {
        logic          is_read;
        logic [DB-1:0] data;
    } exp_t;
    exp_t sb[$];

    sram_ctrl_axil #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .sram_io_addr  (sram_io_addr),
        .sram_io_data  (sram_io_data),
        .sram_io_we_n  (sram_io_we_n),
        .sram_io_oe_n  (sram_io_oe_n),
        .sram_io_ce_n  (sram_io_ce_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM: drives the bus while selected and output-enabled, stores under we_n.
    assign sram_io_data = (!sram_io_ce_n && !sram_io_oe_n) ? mem[sram_io_addr] : {DB{1'bz}};
    always @(posedge clk) if (!sram_io_ce_n && !sram_io_we_n) mem[sram_io_addr] <= sram_io_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Response monitor: pops the scoreboard on each completed B or R handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (!sram_io_we_n && !sram_io_oe_n) overlap_cnt++;
            if (s_axi_awready != s_axi_wready) split_cnt++;
            if (s_axi_bvalid && s_axi_bready) begin
                if (sb.size() == 0) check("b_unexpected", s_axi_bvalid, 1'b0);
                else begin
                    e = sb.pop_front();
                    check("b_order_kind", e.is_read, 1'b0);
                    check("bresp", s_axi_bresp, AXI_RESP_OKAY);
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (sb.size() == 0) check("r_unexpected", s_axi_rvalid, 1'b0);
                else begin
                    e = sb.pop_front();
                    check("r_order_kind", e.is_read, 1'b1);
                    check("rdata", s_axi_rdata, e.data);
                    check("rresp", s_axi_rresp, AXI_RESP_OKAY);
                end
            end
        end
    end

    task automatic axi_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input bit timing, output int gcyc);
        int waited = 0;
        gcyc = -1;
        @(posedge clk); #1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_awready && waited < 40) begin @(negedge clk); waited++; end
        check("write_handshake", {s_axi_awready, s_axi_wready}, 2'b11);
        if (s_axi_awready) begin
            gcyc = cyc;
            sb.push_back('{is_read: 1'b0, data: '0});
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (timing) begin
            @(negedge clk);
            check("wr_n1_we_n", sram_io_we_n, 1'b0);
            check("wr_n1_ce_n", sram_io_ce_n, 1'b0);
            check("wr_n1_oe_n", sram_io_oe_n, 1'b1);
            check("wr_n1_addr", sram_io_addr, a);
            check("wr_n1_bus", sram_io_data === d, 1'b1);
            @(negedge clk);
            check("wr_n2_we_n", sram_io_we_n, 1'b1);
            check("wr_n2_ce_n", sram_io_ce_n, 1'b0);
            check("wr_n2_addr", sram_io_addr, a);
            check("wr_n2_bus", sram_io_data === d, 1'b1);
            @(negedge clk);
            check("wr_n3_bvalid", s_axi_bvalid, 1'b1);
            check("wr_n3_ce_n", sram_io_ce_n, 1'b1);
            check("wr_n3_we_n", sram_io_we_n, 1'b1);
            check("wr_n3_bus_released", sram_io_data === d, 1'b0);
        end
    endtask

    task automatic axi_read(input logic [AB-1:0] a, input logic [DB-1:0] d, input bit timing, output int gcyc);
        int waited = 0;
        gcyc = -1;
        @(posedge clk); #1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_arready && waited < 40) begin @(negedge clk); waited++; end
        check("read_handshake", s_axi_arready, 1'b1);
        if (s_axi_arready) begin
            gcyc = cyc;
            sb.push_back('{is_read: 1'b1, data: d});
        end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        if (timing) begin
            @(negedge clk);
            check("rd_n1_oe_n", sram_io_oe_n, 1'b0);
            check("rd_n1_ce_n", sram_io_ce_n, 1'b0);
            check("rd_n1_we_n", sram_io_we_n, 1'b1);
            check("rd_n1_addr", sram_io_addr, a);
            @(negedge clk);
            check("rd_n2_oe_n", sram_io_oe_n, 1'b0);
            check("rd_n2_rvalid", s_axi_rvalid, 1'b0);
            @(negedge clk);
            check("rd_n3_rvalid", s_axi_rvalid, 1'b1);
            check("rd_n3_rdata", s_axi_rdata, d);
            check("rd_n3_oe_n", sram_io_oe_n, 1'b1);
            check("rd_n3_ce_n", sram_io_ce_n, 1'b1);
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 40) begin @(negedge clk); waited++; end
        @(posedge clk); #1;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            g;
        int            g0;
        int            waited;
        bit            exp_rd    [4];
        logic [DB-1:0] exp_rdata [4];

        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ce_n", sram_io_ce_n, 1'b1);
        check("rst_we_n", sram_io_we_n, 1'b1);
        check("rst_oe_n", sram_io_oe_n, 1'b1);
        check("rst_addr", sram_io_addr, 4'h0);
        check("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        check("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        check("rst_rdata", s_axi_rdata, 2'b00);
        check("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single write then read-back with exact latency checks.
        axi_write(4'h3, 2'b10, 1'b1, g);
        axi_read(4'h3, 2'b10, 1'b1, g);
        drain();

        // All three valids held: grants alternate write, read, write, read.
        exp_rd    = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_rdata = '{2'b00, 2'b01, 2'b00, 2'b10};
        s_axi_awaddr = 4'h5; s_axi_wdata = 2'b01; s_axi_araddr = 4'h5;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            @(negedge clk);
            while (!(s_axi_awready || s_axi_arready) && waited < 40) begin @(negedge clk); waited++; end
            check("rr_grant_is_read", s_axi_arready, exp_rd[k]);
            check("rr_grant_exclusive", s_axi_awready && s_axi_arready, 1'b0);
            sb.push_back('{is_read: exp_rd[k], data: exp_rdata[k]});
            @(posedge clk); #1;
            if (k == 0) s_axi_wdata = 2'b10;
            if (k == 3) begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0; end
        end
        drain();

        // Full sweep: write addr[1:0]^01 everywhere, read everything back.
        g0 = 0;
        for (int i = 0; i < 16; i++) begin
            axi_write(i[3:0], i[1:0] ^ 2'b01, 1'b0, g);
            if (i == 0) g0 = g;
            if (i == 1) check("write_spacing", g - g0, 4);
        end
        drain();
        for (int i = 0; i < 16; i++) begin
            axi_read(i[3:0], i[1:0] ^ 2'b01, 1'b0, g);
            if (i == 0) g0 = g;
            if (i == 1) check("read_spacing", g - g0, 4);
        end
        drain();
        check("we_oe_overlap_sweep", overlap_cnt, 0);

        // Read backpressure: response held stable, no new handshake meanwhile.
        s_axi_rready = 1'b0;
        axi_read(4'h3, 2'b10, 1'b0, g);
        s_axi_araddr = 4'h4; s_axi_arvalid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!s_axi_rvalid && waited < 40) begin @(negedge clk); waited++; end
        for (int i = 0; i < 5; i++) begin
            check("stall_rvalid", s_axi_rvalid, 1'b1);
            check("stall_rdata", s_axi_rdata, 2'b10);
            check("stall_arready", s_axi_arready, 1'b0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        s_axi_rready = 1'b1;
        @(negedge clk);
        check("stall_release_rvalid", s_axi_rvalid, 1'b1);
        @(negedge clk);
        check("stall_rvalid_dropped", s_axi_rvalid, 1'b0);
        waited = 0;
        while (!s_axi_arready && waited < 40) begin @(negedge clk); waited++; end
        check("stall_next_read_granted", s_axi_arready, 1'b1);
        if (s_axi_arready) sb.push_back('{is_read: 1'b1, data: 2'b01});
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        drain();

        // awvalid alone must not handshake; the write completes once wvalid joins.
        @(posedge clk); #1;
        s_axi_awaddr = 4'h9; s_axi_wdata = 2'b11; s_axi_awvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("aw_alone_no_ready", {s_axi_awready, s_axi_wready}, 2'b00);
        end
        @(posedge clk); #1;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("aw_w_joined_ready", {s_axi_awready, s_axi_wready}, 2'b11);
        if (s_axi_awready) sb.push_back('{is_read: 1'b0, data: '0});
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("aw_w_joined_bvalid_n3", s_axi_bvalid, 1'b1);
        drain();
        axi_read(4'h9, 2'b11, 1'b0, g);
        drain();

        // Reset during WR_HOLD: pins return to idle, no write response.
        @(posedge clk); #1;
        s_axi_awaddr = 4'hA; s_axi_wdata = 2'b01; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!s_axi_awready && waited < 40) begin @(negedge clk); waited++; end
        check("rst_test_handshake", s_axi_awready, 1'b1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_test_in_hold_we_n", sram_io_we_n, 1'b1);
        check("rst_test_in_hold_ce_n", sram_io_ce_n, 1'b0);
        @(negedge clk);
        check("rst_test_pins", {sram_io_ce_n, sram_io_we_n, sram_io_oe_n}, 3'b111);
        check("rst_test_bus_released", sram_io_data === 2'b01, 1'b0);
        check("rst_test_no_bvalid", s_axi_bvalid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_test_still_no_bvalid", s_axi_bvalid, 1'b0);
        axi_write(4'hA, 2'b10, 1'b1, g);
        axi_read(4'hA, 2'b10, 1'b1, g);
        drain();

        check("we_oe_overlap_total", overlap_cnt, 0);
        check("aw_w_ready_split", split_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
